inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction-fetch stage for the 5-stage MIPS pipeline.
- Owns the PC and issues one-outstanding word fetches on a req/gnt/rvalid instruction bus.
- Registers each fetched word into the IF/ID latch that feeds decode as `addr`/`inst`.
- Consumes decode's branch redirect with MIPS delay-slot semantics, pipeline stall, and exception flush.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- ADDR_WIDTH, 32, width of PC and bus address.
- DATA_WIDTH, 32, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  pipeline hold from the controller (decode load-use stall ORed upstream).
- flush  input  1  exception/eret flush, one cycle.
- flush_pc  input  ADDR_WIDTH  restart address, sampled when flush=1.
- branch_flag  input  1  decode resolved a taken branch/jump this cycle.
- branch_addr  input  ADDR_WIDTH  branch target, valid with branch_flag.
- ibus_req  output  1  fetch request.
- ibus_addr  output  ADDR_WIDTH  fetch address; stable while ibus_req=1 and ibus_gnt=0.
- ibus_gnt  input  1  request accepted this cycle.
- ibus_rvalid  input  1  read data valid; only after a grant; one per grant.
- ibus_rdata  input  DATA_WIDTH  fetched instruction.
- id_valid  output  1  IF/ID latch holds a real instruction.
- id_addr  output  ADDR_WIDTH  PC of latched instruction.
- id_inst  output  DATA_WIDTH  latched instruction; 0 (nop) when id_valid=0.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=S_REQ.
  - id_valid=0, id_addr=0, id_inst=0.
  - redirect_pending=0, discard=0.
  - ibus_req is forced 0 while rst=0.
- States:
  - S_REQ: ibus_req=1, ibus_addr=pc. On gnt go to S_WAIT.
  - S_WAIT: wait for rvalid.
  - S_HOLD: one fetched word is buffered (hold_inst, hold_addr) because stall was high when it arrived.
- Delivery event: occurs on rvalid in S_WAIT with discard=0 and stall=0, or in S_HOLD when stall=0. On delivery:
  - id_addr/id_inst/id_valid load the word, its address and 1 at the next edge.
  - pc <= redirect_pending ? redirect_addr : pc+4.
  - redirect_pending clears.
  - State returns to S_REQ.
- rvalid in S_WAIT with stall=1: capture into the hold buffer and go to S_HOLD. pc and the ID latch are unchanged.
- stall=1: the ID latch holds its value. When stall=0 and there is no delivery, id_valid<=0 and id_inst<=0 (bubble).
- Branch capture: when branch_flag=1, id_valid=1 and stall=0, set redirect_pending=1 and redirect_addr=branch_addr. The word in flight or next fetched is the delay slot; it is delivered normally and the following fetch is from the target.
- Flush (priority over stall and branch):
  - pc <= flush_pc.
  - id_valid<=0, id_inst<=0.
  - redirect_pending<=0; hold buffer dropped.
  - If in S_WAIT, or granted in S_REQ that same cycle: discard<=1 and state=S_WAIT. The next rvalid is dropped, discard clears, and state goes to S_REQ.
  - Otherwise state goes to S_REQ.
- A flush arriving on the same cycle as rvalid drops that word.
- Latency: rvalid at cycle N gives id_valid=1 at N+1. The next ibus_req is at N+1. Zero-wait bus throughput is one instruction per 2 cycles.
- pc wraps modulo 2^ADDR_WIDTH.
- ibus_addr[1:0] is forwarded unchecked; alignment faults are raised downstream.

Test Plan:
- Reset, then zero-wait bus (gnt with req, rvalid next cycle) -> ibus_addr sequence BFC00000, BFC00004, BFC00008; id_valid pulses with matching id_addr every 2 cycles.
- gnt delayed 3 cycles at BFC00004 -> ibus_addr stays BFC00004 throughout; no request is issued before the outstanding rvalid.
- stall=1 across an rvalid of word 0x24020001 at BFC00008 -> ID latch frozen on the previous instruction. On stall release, id_inst=0x24020001 and id_addr=BFC00008 the next cycle, with no extra fetch.
- Branch at BFC00010 in ID with branch_flag=1 and branch_addr=BFC00100 -> delay slot BFC00014 delivered, then fetches continue at BFC00100, BFC00104.
- flush with flush_pc=BFC00380 while in S_WAIT for BFC00020 -> id_valid=0 next cycle; the returning word is dropped; next ibus_addr=BFC00380.
- rst driven low mid-S_WAIT -> outputs return to reset values immediately; ibus_req=0 until release, then the first request is at BFC00000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - MIPS instruction fetch stage: PC, one-outstanding ibus fetch, IF/ID latch
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  ibus_req,
  output logic [ADDR_WIDTH-1:0] ibus_addr,
  input  logic                  ibus_gnt,
  input  logic                  ibus_rvalid,
  input  logic [DATA_WIDTH-1:0] ibus_rdata,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_addr,
  output logic [DATA_WIDTH-1:0] id_inst
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_redirect_addr;
  logic                  r_redirect_pending;
  logic                  r_discard;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [DATA_WIDTH-1:0] r_hold_inst;
  logic                  r_id_valid;
  logic [ADDR_WIDTH-1:0] r_id_addr;
  logic [DATA_WIDTH-1:0] r_id_inst;

  logic                  w_deliver_wait;
  logic                  w_deliver_hold;
  logic                  w_deliver;
  logic                  w_branch_cap;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [ADDR_WIDTH-1:0] w_deliver_addr;
  logic [DATA_WIDTH-1:0] w_deliver_inst;

  assign w_deliver_wait = (r_state == S_WAIT) && ibus_rvalid && !r_discard && !stall;
  assign w_deliver_hold = (r_state == S_HOLD) && !stall;
  assign w_deliver      = w_deliver_wait || w_deliver_hold;
  assign w_branch_cap   = branch_flag && r_id_valid && !stall;

  // A branch seen while its delay slot is being delivered redirects straight to the target
  assign w_next_pc      = w_branch_cap       ? branch_addr     :
                          r_redirect_pending ? r_redirect_addr :
                                               r_pc + ADDR_WIDTH'(4);
  assign w_deliver_addr = w_deliver_hold ? r_hold_addr : r_pc;
  assign w_deliver_inst = w_deliver_hold ? r_hold_inst : ibus_rdata;

  assign ibus_req  = rst && (r_state == S_REQ);
  assign ibus_addr = r_pc;
  assign id_valid  = r_id_valid;
  assign id_addr   = r_id_addr;
  assign id_inst   = r_id_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state            <= S_REQ;
      r_pc               <= RESET_PC;
      r_redirect_addr    <= '0;
      r_redirect_pending <= 1'b0;
      r_discard          <= 1'b0;
      r_hold_addr        <= '0;
      r_hold_inst        <= '0;
      r_id_valid         <= 1'b0;
      r_id_addr          <= '0;
      r_id_inst          <= '0;
    end else if (flush) begin
      r_pc               <= flush_pc;
      r_id_valid         <= 1'b0;
      r_id_inst          <= '0;
      r_redirect_pending <= 1'b0;
      // Drop the response of a transaction already accepted by the bus
      if (((r_state == S_WAIT) && !ibus_rvalid) || ((r_state == S_REQ) && ibus_gnt)) begin
        r_discard <= 1'b1;
        r_state   <= S_WAIT;
      end else begin
        r_discard <= 1'b0;
        r_state   <= S_REQ;
      end
    end else if (w_deliver) begin
      r_id_valid         <= 1'b1;
      r_id_addr          <= w_deliver_addr;
      r_id_inst          <= w_deliver_inst;
      r_pc               <= w_next_pc;
      r_redirect_pending <= 1'b0;
      r_state            <= S_REQ;
    end else begin
      if (!stall) begin
        r_id_valid <= 1'b0;
        r_id_inst  <= '0;
      end
      if (w_branch_cap) begin
        r_redirect_pending <= 1'b1;
        r_redirect_addr    <= branch_addr;
      end
      case (r_state)
        S_REQ: begin
          if (ibus_gnt) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (ibus_rvalid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_hold_addr <= r_pc;
              r_hold_inst <= ibus_rdata;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: r_state <= S_HOLD;
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
